pwm_decoder: RTL and testbench
==============================

PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the high-time and period counters.
REQ-002 SHALL have parameter NUM_CH, default 3: number of PWM input channels.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port pwm_in, input, NUM_CH: asynchronous PWM lines; bit 0 red, bit 1 green, bit 2 blue.
REQ-006 SHALL have port meas_valid, output, 1: result available.
REQ-007 SHALL have port meas_ready, input, 1: consumer accepts result.
REQ-008 SHALL have port meas_ch, output, 2: channel index of result.
REQ-009 SHALL have port meas_high, output, CNT_W: synced-high cycles in the measured period.
REQ-010 SHALL have port meas_period, output, CNT_W: cycles between consecutive rising edges.
REQ-011 SHALL have port meas_sat, output, 1: result is a stall report, not a full period.
REQ-012 SHALL have port overrun, output, NUM_CH: sticky per-channel overrun flags.
REQ-013 SHALL have port overrun_clr, input, 1: synchronous clear of all overrun flags.

Function
REQ-014 SHALL pass each pwm_in bit through a 2-flop synchronizer plus 1 history flop; rising edge = synced 1, history 0.
REQ-015 Per-channel FSM SHALL have states WAIT_EDGE, MEASURE and STALLED; it leaves reset in WAIT_EDGE.
REQ-016 WAIT_EDGE -> MEASURE on first rising edge; both counters load 1 (high) and 1 (period); the partial first period is discarded.
REQ-017 In MEASURE, each cycle without an edge: period += 1; high += 1 when synced line is 1.
REQ-018 A rising edge in MEASURE SHALL latch {high, period} into the channel's pending slot, set pending, and reload the counters to 1/1 in the same cycle.
REQ-019 When period reaches 2^CNT_W-1 without an edge: latch period = all ones, high = all ones if line is 1 else 0, set sat, go to STALLED; no further reports are made while in STALLED.
REQ-020 STALLED -> MEASURE on next rising edge, with the counters reloaded to 1/1 and no result latched for that edge.
REQ-021 Output stage SHALL be one register set; it loads when empty or when meas_valid&&meas_ready, from a pending channel chosen round-robin starting after the last granted index.
REQ-022 Latency: pending set in cycle N -> meas_valid high in cycle N+1 when the output stage is free.
REQ-023 meas_* SHALL be held stable while meas_valid=1 and meas_ready=0.
REQ-024 A new latch into an already-pending slot SHALL overwrite it (newest wins) and set overrun[ch].
REQ-025 Simultaneous grant and new latch on the same channel: the granted (old) value goes out, the new value stays pending, and no overrun is flagged.
REQ-026 overrun_clr and a new overrun in the same cycle: the flag SHALL end set.

Reset
REQ-027 rst SHALL force: meas_valid=0, meas_ch=0, meas_high=0, meas_period=0, meas_sat=0, overrun=0, all FSMs to WAIT_EDGE, synchronizers to 0, pending cleared, round-robin pointer to 0.
REQ-028 rst asserted mid-period or mid-handshake SHALL discard all results; there is no recovery of in-flight data.

Configuration
REQ-029 Macro PWM_DECODER_OVERRUN_EN: defined -> REQ-024/026 overrun logic is built; undefined -> overrun is tied to 0, overrun_clr is ignored, and overwrite (newest wins) still applies.

Structure
REQ-030 Package pwm_decoder_pkg SHALL hold the CNT_W default, the channel FSM state enum, and the result struct {high, period, sat}.
REQ-031 Sub-module pwm_decoder_ch SHALL implement one channel (sync, edge detect, FSM, counters, pending slot); the top instantiates NUM_CH copies plus the arbiter/output stage.

Verification
REQ-032 pwm_in[0] period 10, high 3, meas_ready=1 -> first result discarded, then repeated {ch 0, high 3, period 10, sat 0}.
REQ-033 All 3 channels edge in the same cycle, ready=1 -> results on three consecutive cycles in order 0,1,2; next burst starts from the index after the last grant.
REQ-034 CNT_W=8, pwm_in[1] held 1 after an edge -> one result {ch 1, high 255, period 255, sat 1}, then silence until the next edge.
REQ-035 ch 2 period 5, meas_ready=0 for 20 cycles -> output holds the first value, overrun[2]=1 (macro defined) or 0 (undefined), and the first result after ready=1 is the newest pending value.
REQ-036 rst pulse mid-period and while meas_valid=1 -> all outputs 0 immediately; the first post-reset period is discarded.

Source files
------------

// File: rtl/pwm_decoder_pkg.sv
// Shared types for the PWM decoder: counter default, channel FSM states, result record
// and the round-robin index helper.
package pwm_decoder_pkg;

   localparam int unsigned CNT_W_DEF = 24;
   // Results are carried at this width; channels zero-extend CNT_W-bit counts into it.
   localparam int unsigned CNT_W_MAX = 32;

   typedef enum logic [1:0] {
      WAIT_EDGE,
      MEASURE,
      STALLED
   } ch_state_e;

   typedef struct packed {
      logic [CNT_W_MAX-1:0] high;
      logic [CNT_W_MAX-1:0] period;
      logic                 sat;
   } pwm_res_t;

   // (base + off) modulo num_ch, for base < num_ch <= 4 and off < num_ch.
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned off,
                                         input int unsigned num_ch);
      logic [2:0] s;
      s = {1'b0, base} + 3'(off);
      if (s >= 3'(num_ch)) s = s - 3'(num_ch);
      return s[1:0];
   endfunction

endpackage

// File: rtl/pwm_decoder_ch.sv
// One PWM channel: synchronizer, rising-edge detect, measurement FSM and pending slot.
// Overrun flag is built only when PWM_DECODER_OVERRUN_EN is defined.
module pwm_decoder_ch
   import pwm_decoder_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_pwm,
   input  logic     i_grant,
   input  logic     i_overrun_clr,
   output logic     o_pending,
   output pwm_res_t o_res,
   output logic     o_overrun
);

   localparam logic [CNT_W-1:0] SAT_M1 = {{(CNT_W-1){1'b1}}, 1'b0};

   logic             r_sync1, r_sync2, r_hist;
   ch_state_e        r_state;
   logic [CNT_W-1:0] r_high, r_period;
   logic             r_pending;
   pwm_res_t         r_res;
   logic             w_rise, w_latch;
   pwm_res_t         w_new;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
      end else begin
         r_sync1 <= i_pwm;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_hist;

   // Result capture: full period on an edge, or a stall report once period would hit all ones.
   always_comb begin
      w_latch = 1'b0;
      w_new   = '0;
      if (r_state == MEASURE) begin
         if (w_rise) begin
            w_latch      = 1'b1;
            w_new.high   = CNT_W_MAX'(r_high);
            w_new.period = CNT_W_MAX'(r_period);
         end else if (r_period == SAT_M1) begin
            w_latch      = 1'b1;
            w_new.high   = r_sync2 ? CNT_W_MAX'({CNT_W{1'b1}}) : '0;
            w_new.period = CNT_W_MAX'({CNT_W{1'b1}});
            w_new.sat    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= WAIT_EDGE;
         r_high   <= '0;
         r_period <= '0;
      end else begin
         case (r_state)
            WAIT_EDGE, STALLED: begin
               if (w_rise) begin
                  r_state  <= MEASURE;
                  r_high   <= CNT_W'(1);
                  r_period <= CNT_W'(1);
               end
            end
            MEASURE: begin
               if (w_rise) begin
                  r_high   <= CNT_W'(1);
                  r_period <= CNT_W'(1);
               end else if (r_period == SAT_M1) begin
                  r_state <= STALLED;
               end else begin
                  r_period <= r_period + CNT_W'(1);
                  r_high   <= r_high + CNT_W'(r_sync2);
               end
            end
            default: r_state <= WAIT_EDGE;
         endcase
      end
   end

   // A latch coinciding with a grant keeps the new value pending; the old one is taken.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pending <= 1'b0;
         r_res     <= '0;
      end else if (w_latch) begin
         r_pending <= 1'b1;
         r_res     <= w_new;
      end else if (i_grant) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_res     = r_res;

`ifdef PWM_DECODER_OVERRUN_EN
   logic r_overrun;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_overrun <= 1'b0;
      end else if (w_latch && r_pending && !i_grant) begin
         r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign o_overrun = r_overrun;
`else
   logic w_unused_clr;
   assign w_unused_clr = i_overrun_clr;
   assign o_overrun    = 1'b0;
`endif

endmodule

// File: rtl/pwm_decoder.sv
// Multi-channel PWM high-time/period decoder with a round-robin single-entry output stage.
// Define PWM_DECODER_OVERRUN_EN to build the sticky per-channel overrun flags.
module pwm_decoder
   import pwm_decoder_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned NUM_CH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] pwm_in,
   output logic              meas_valid,
   input  logic              meas_ready,
   output logic [1:0]        meas_ch,
   output logic [CNT_W-1:0]  meas_high,
   output logic [CNT_W-1:0]  meas_period,
   output logic              meas_sat,
   output logic [NUM_CH-1:0] overrun,
   input  logic              overrun_clr
);

   // Arbitration works on 4 slots (the 2-bit channel index range); unused slots never request.
   logic [3:0] w_pend;
   pwm_res_t   w_res [4];
   logic       w_load, w_found;
   logic [1:0] w_gnt_idx;
   logic       r_valid;
   logic [1:0] r_ch, r_ptr;
   pwm_res_t   r_out;

   for (genvar g = 0; g < 4; g++) begin : g_ch
      if (g < NUM_CH) begin : g_inst
         pwm_decoder_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_pwm         (pwm_in[g]),
            .i_grant       (w_load && w_found && (w_gnt_idx == 2'(g))),
            .i_overrun_clr (overrun_clr),
            .o_pending     (w_pend[g]),
            .o_res         (w_res[g]),
            .o_overrun     (overrun[g])
         );
      end else begin : g_tie
         assign w_pend[g] = 1'b0;
         assign w_res[g]  = '0;
      end
   end

   assign w_load = !r_valid || meas_ready;

   // r_ptr is the first index searched; it moves to one past each grant.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = 2'd0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!w_found && w_pend[rr_idx(r_ptr, i, NUM_CH)]) begin
            w_found   = 1'b1;
            w_gnt_idx = rr_idx(r_ptr, i, NUM_CH);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ch    <= 2'd0;
         r_ptr   <= 2'd0;
         r_out   <= '0;
      end else if (w_load) begin
         r_valid <= w_found;
         if (w_found) begin
            r_ch  <= w_gnt_idx;
            r_out <= w_res[w_gnt_idx];
            r_ptr <= rr_idx(w_gnt_idx, 1, NUM_CH);
         end
      end
   end

   assign meas_valid  = r_valid;
   assign meas_ch     = r_ch;
   assign meas_high   = CNT_W'(r_out.high);
   assign meas_period = CNT_W'(r_out.period);
   assign meas_sat    = r_out.sat;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder (CNT_W=8): basic measure, round-robin, stall, overrun, reset.
module tb_pwm_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] pwm_in;
   logic       meas_valid, meas_ready, meas_sat, overrun_clr;
   logic [1:0] meas_ch;
   logic [7:0] meas_high, meas_period;
   logic [2:0] overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {int ch; int hi; int per; int sat; int cyc;} tr_t;
   tr_t trq[$];

   logic [2:0] gen_mode, gen_lvl, gen_prev;
   int         gen_per[3], gen_hi[3], gen_cnt[3];

`ifdef PWM_DECODER_OVERRUN_EN
   localparam logic [2:0] EXP_OVR = 3'b100;
`else
   localparam logic [2:0] EXP_OVR = 3'b000;
`endif

   always #5 clk = ~clk;

   pwm_decoder #(
      .CNT_W  (8),
      .NUM_CH (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .meas_valid  (meas_valid),
      .meas_ready  (meas_ready),
      .meas_ch     (meas_ch),
      .meas_high   (meas_high),
      .meas_period (meas_period),
      .meas_sat    (meas_sat),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   // PWM generator: mode 1 = periodic waveform, mode 0 = static level.
   initial begin
      pwm_in   = '0;
      gen_prev = '0;
      for (int c = 0; c < 3; c++) gen_cnt[c] = 0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            if (gen_mode[c]) begin
               if (!gen_prev[c]) gen_cnt[c] = 0;
               pwm_in[c]  = (gen_cnt[c] < gen_hi[c]);
               gen_cnt[c] = (gen_cnt[c] + 1) % gen_per[c];
            end else begin
               pwm_in[c] = gen_lvl[c];
            end
            gen_prev[c] = gen_mode[c];
         end
      end
   end

   // Transfer monitor
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (meas_valid === 1'b1 && meas_ready === 1'b1)
            trq.push_back('{int'(meas_ch), int'(meas_high), int'(meas_period), int'(meas_sat), cyc});
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tr(input int budget, input int idx, output bit ok);
      int n = 0;
      while (trq.size() <= idx && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      ok = (trq.size() > idx);
   endtask

   task automatic do_reset;
      rst         = 1'b1;
      gen_mode    = '0;
      gen_lvl     = '0;
      meas_ready  = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset;
      repeat (2) tick();
      n_checks++;
      if (meas_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b required 0", meas_valid);
      end
      n_checks++;
      if (meas_ch !== 2'd0) begin
         n_fail++; $display("FAIL reset_ch: got %0d required 0", meas_ch);
      end
      n_checks++;
      if (meas_high !== 8'd0) begin
         n_fail++; $display("FAIL reset_high: got %0d required 0", meas_high);
      end
      n_checks++;
      if (meas_period !== 8'd0) begin
         n_fail++; $display("FAIL reset_period: got %0d required 0", meas_period);
      end
      n_checks++;
      if (meas_sat !== 1'b0) begin
         n_fail++; $display("FAIL reset_sat: got %b required 0", meas_sat);
      end
      n_checks++;
      if (overrun !== 3'b000) begin
         n_fail++; $display("FAIL reset_overrun: got %b required 000", overrun);
      end
   endtask

   task automatic test_basic;
      int rd;
      bit ok;
      do_reset();
      meas_ready = 1'b1;
      rd = trq.size();
      gen_per[0] = 10; gen_hi[0] = 3; gen_mode[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_tr(60, rd + k, ok);
         n_checks++;
         if (!ok) begin
            n_fail++; $display("FAIL basic_tr%0d: no result, required ch0 high3 period10", k);
         end else if (trq[rd+k].ch !== 0 || trq[rd+k].hi !== 3 || trq[rd+k].per !== 10 ||
                      trq[rd+k].sat !== 0) begin
            n_fail++;
            $display("FAIL basic_tr%0d: got ch%0d high%0d period%0d sat%0d, required ch0 high3 period10 sat0",
                     k, trq[rd+k].ch, trq[rd+k].hi, trq[rd+k].per, trq[rd+k].sat);
         end
         if (ok && k > 0) begin
            n_checks++;
            if (trq[rd+k].cyc - trq[rd+k-1].cyc !== 10) begin
               n_fail++; $display("FAIL basic_spacing%0d: got %0d cycles required 10", k,
                                  trq[rd+k].cyc - trq[rd+k-1].cyc);
            end
         end
      end
   endtask

   task automatic test_round_robin;
      int rd;
      bit ok;
      int exp_ch[8];
      exp_ch = '{1, 1, 2, 0, 1, 2, 0, 1};
      do_reset();
      meas_ready = 1'b1;
      rd = trq.size();
      for (int c = 0; c < 3; c++) begin gen_per[c] = 20; gen_hi[c] = 5; end
      gen_mode = 3'b010;
      repeat (40) tick();
      gen_mode = 3'b111;
      for (int k = 0; k < 8; k++) begin
         wait_tr(80, rd + k, ok);
         n_checks++;
         if (!ok) begin
            n_fail++; $display("FAIL rr_tr%0d: no result, required ch%0d", k, exp_ch[k]);
         end else if (trq[rd+k].ch !== exp_ch[k] || trq[rd+k].hi !== 5 || trq[rd+k].per !== 20 ||
                      trq[rd+k].sat !== 0) begin
            n_fail++;
            $display("FAIL rr_tr%0d: got ch%0d high%0d period%0d sat%0d, required ch%0d high5 period20 sat0",
                     k, trq[rd+k].ch, trq[rd+k].hi, trq[rd+k].per, trq[rd+k].sat, exp_ch[k]);
         end
      end
      n_checks++;
      if (trq[rd+4].cyc - trq[rd+2].cyc !== 2) begin
         n_fail++; $display("FAIL rr_burst_consecutive: got span %0d required 2",
                            trq[rd+4].cyc - trq[rd+2].cyc);
      end
      n_checks++;
      if (trq[rd+5].cyc - trq[rd+2].cyc !== 20) begin
         n_fail++; $display("FAIL rr_burst_spacing: got %0d required 20",
                            trq[rd+5].cyc - trq[rd+2].cyc);
      end
   endtask

   task automatic test_stall;
      int rd;
      int t0;
      bit ok;
      do_reset();
      meas_ready = 1'b1;
      rd = trq.size();
      gen_lvl[1] = 1'b1;
      wait_tr(400, rd, ok);
      n_checks++;
      if (!ok || trq[rd].ch !== 1 || trq[rd].hi !== 255 || trq[rd].per !== 255 || trq[rd].sat !== 1)
      begin
         n_fail++;
         $display("FAIL stall_high: got ch%0d high%0d period%0d sat%0d, required ch1 high255 period255 sat1",
                  trq[rd].ch, trq[rd].hi, trq[rd].per, trq[rd].sat);
      end
      repeat (300) tick();
      n_checks++;
      if (trq.size() !== rd + 1) begin
         n_fail++; $display("FAIL stall_silence: got %0d results required 1", trq.size() - rd);
      end
      gen_lvl[1] = 1'b0;
      repeat (5) tick();
      gen_lvl[1] = 1'b1;
      repeat (100) tick();
      n_checks++;
      if (trq.size() !== rd + 1) begin
         n_fail++; $display("FAIL stall_restart_edge: got %0d results required 1", trq.size() - rd);
      end
      wait_tr(300, rd + 1, ok);
      n_checks++;
      if (!ok || trq[rd+1].ch !== 1 || trq[rd+1].per !== 255 || trq[rd+1].sat !== 1) begin
         n_fail++; $display("FAIL stall_again: got ch%0d period%0d sat%0d, required ch1 period255 sat1",
                            trq[rd+1].ch, trq[rd+1].per, trq[rd+1].sat);
      end

      do_reset();
      meas_ready = 1'b1;
      rd = trq.size();
      t0 = cyc;
      gen_lvl[0] = 1'b1;
      repeat (3) tick();
      gen_lvl[0] = 1'b0;
      wait_tr(400, rd, ok);
      n_checks++;
      if (!ok || trq[rd].ch !== 0 || trq[rd].hi !== 0 || trq[rd].per !== 255 || trq[rd].sat !== 1)
      begin
         n_fail++;
         $display("FAIL stall_low: got ch%0d high%0d period%0d sat%0d, required ch0 high0 period255 sat1",
                  trq[rd].ch, trq[rd].hi, trq[rd].per, trq[rd].sat);
      end
      n_checks++;
      if (trq[rd].cyc - t0 !== 259) begin
         n_fail++; $display("FAIL stall_latency: got %0d cycles required 259", trq[rd].cyc - t0);
      end
   endtask

   task automatic test_overrun;
      int  rd;
      int  n;
      bit  ok;
      bit  held_ok;
      do_reset();
      rd = trq.size();
      gen_per[2] = 5; gen_hi[2] = 2; gen_mode[2] = 1'b1;
      n = 0;
      while (meas_valid !== 1'b1 && n < 100) begin tick(); n++; end
      n_checks++;
      if (meas_valid !== 1'b1) begin
         n_fail++; $display("FAIL ovr_first_valid: got %b required 1", meas_valid);
      end
      held_ok = 1'b1;
      repeat (20) begin
         tick();
         if (meas_valid !== 1'b1 || meas_ch !== 2'd2 || meas_high !== 8'd2 ||
             meas_period !== 8'd5 || meas_sat !== 1'b0) held_ok = 1'b0;
      end
      n_checks++;
      if (!held_ok) begin
         n_fail++;
         $display("FAIL ovr_hold: got valid%b ch%0d high%0d period%0d, required stable valid1 ch2 high2 period5",
                  meas_valid, meas_ch, meas_high, meas_period);
      end
      n_checks++;
      if (overrun !== EXP_OVR) begin
         n_fail++; $display("FAIL ovr_flag: got %b required %b", overrun, EXP_OVR);
      end
      gen_per[2] = 7; gen_hi[2] = 3;
      repeat (30) tick();
      meas_ready = 1'b1;
      wait_tr(10, rd + 1, ok);
      n_checks++;
      if (!ok || trq[rd].ch !== 2 || trq[rd].hi !== 2 || trq[rd].per !== 5) begin
         n_fail++; $display("FAIL ovr_held_out: got ch%0d high%0d period%0d, required ch2 high2 period5",
                            trq[rd].ch, trq[rd].hi, trq[rd].per);
      end
      n_checks++;
      if (!ok || trq[rd+1].ch !== 2 || trq[rd+1].hi !== 3 || trq[rd+1].per !== 7) begin
         n_fail++; $display("FAIL ovr_newest: got ch%0d high%0d period%0d, required ch2 high3 period7",
                            trq[rd+1].ch, trq[rd+1].hi, trq[rd+1].per);
      end
      gen_mode[2] = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (overrun !== EXP_OVR) begin
         n_fail++; $display("FAIL ovr_sticky: got %b required %b", overrun, EXP_OVR);
      end
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 3'b000) begin
         n_fail++; $display("FAIL ovr_clear: got %b required 000", overrun);
      end
   endtask

   task automatic test_reset_mid;
      int rd;
      int n;
      bit ok;
      do_reset();
      gen_per[0] = 10; gen_hi[0] = 3; gen_mode[0] = 1'b1;
      n = 0;
      while (meas_valid !== 1'b1 && n < 100) begin tick(); n++; end
      n = 0;
      while (gen_cnt[0] != 6 && n < 20) begin tick(); n++; end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({meas_valid, meas_ch, meas_high, meas_period, meas_sat, overrun} !== 23'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got valid%b ch%0d high%0d period%0d sat%b ovr%b, required all 0",
                  meas_valid, meas_ch, meas_high, meas_period, meas_sat, overrun);
      end
      tick();
      rst        = 1'b0;
      meas_ready = 1'b1;
      rd         = trq.size();
      wait_tr(100, rd, ok);
      n_checks++;
      if (!ok || trq[rd].ch !== 0 || trq[rd].hi !== 3 || trq[rd].per !== 10 || trq[rd].sat !== 0)
      begin
         n_fail++;
         $display("FAIL midreset_first: got ch%0d high%0d period%0d sat%0d, required ch0 high3 period10 sat0",
                  trq[rd].ch, trq[rd].hi, trq[rd].per, trq[rd].sat);
      end
   endtask

   initial begin
      rst         = 1'b1;
      meas_ready  = 1'b0;
      overrun_clr = 1'b0;
      gen_mode    = '0;
      gen_lvl     = '0;
      for (int c = 0; c < 3; c++) begin gen_per[c] = 10; gen_hi[c] = 0; end
      test_reset();
      test_basic();
      test_round_robin();
      test_stall();
      test_overrun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
